// File: rtl/adc_scan_sequencer.sv
// Purpose: autonomous round-robin scan controller for an 8-channel 12-bit SPI ADC;
//          generates cs_n/sclk/saddr, undoes the one-frame address pipeline, tags results.
// Latency: result of the address sent in frame N strobes at the first STOP cycle of frame N+1.
// Backpressure: none; res_stb is a fire-and-forget pulse, the bank holds the last value per channel.
// Ports: clk/rst (sync, active high); enable, ch_mask control the scan;
//        sdat/sclk/cs_n/saddr form the ADC serial link; busy is high outside IDLE;
//        res_stb/res_ch/res_data form the result stream; rd_ch/rd_data/rd_valid read the bank.
module adc_scan_sequencer #(
  parameter int DIV = 4,  // clk cycles per SCLK half-period, 2..255
  parameter int GAP = 2   // SCLK periods with cs_n high between frames, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic        sdat,
  output logic        sclk,
  output logic        cs_n,
  output logic        saddr,
  output logic        busy,
  output logic        res_stb,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        rd_valid
);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  localparam logic [12:0] HALF_LAST = 13'(DIV - 1);
  localparam logic [12:0] STOP_LAST = 13'(GAP * 2 * DIV - 1);

  state_t      state;
  logic [12:0] cnt;        // cycle counter within START, an SCLK half, or STOP
  logic [3:0]  per;        // SCLK period index inside SHIFT
  logic        hi_half;    // 0: sclk low half of the period, 1: high half
  logic [2:0]  addr;       // address sent in the current frame
  logic [2:0]  last_addr;  // round-robin pointer
  logic [2:0]  prev_addr;  // address whose data is being shifted in now
  logic        prev_ok;    // prev_addr refers to a real frame sent since IDLE
  logic [11:0] shreg;
  logic [11:0] bank [8];
  logic [7:0]  bank_vld;

  logic        go;
  logic [2:0]  nxt_addr;

  // Lowest set mask bit strictly above 'last', wrapping past 7 back to 0.
  function automatic logic [2:0] pick_next(input logic [7:0] mask, input logic [2:0] last);
    logic [2:0] c;
    logic       found;
    pick_next = last;
    found     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = last + 3'(i);
      if (!found && mask[c]) begin
        pick_next = c;
        found     = 1'b1;
      end
    end
  endfunction

  // Address bits go out MSB first in periods 2..4; the line is 0 otherwise.
  function automatic logic addr_bit(input logic [3:0] p, input logic [2:0] a);
    case (p)
      4'd2:    addr_bit = a[2];
      4'd3:    addr_bit = a[1];
      4'd4:    addr_bit = a[0];
      default: addr_bit = 1'b0;
    endcase
  endfunction

  assign go       = enable && (ch_mask != 8'h00);
  assign nxt_addr = pick_next(ch_mask, last_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      per       <= '0;
      hi_half   <= 1'b0;
      addr      <= '0;
      last_addr <= 3'd7;
      prev_addr <= '0;
      prev_ok   <= 1'b0;
      shreg     <= '0;
      sclk      <= 1'b1;
      cs_n      <= 1'b1;
      saddr     <= 1'b0;
      busy      <= 1'b0;
      res_stb   <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      bank_vld  <= '0;
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      res_stb <= 1'b0;
      case (state)
        IDLE: begin
          cs_n  <= 1'b1;
          sclk  <= 1'b1;
          saddr <= 1'b0;
          busy  <= 1'b0;
          if (go) begin
            state     <= START;
            addr      <= nxt_addr;
            last_addr <= nxt_addr;
            cs_n      <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            state   <= SHIFT;
            per     <= '0;
            hi_half <= 1'b0;
            sclk    <= 1'b0;
            saddr   <= addr_bit(4'd0, addr);
          end else begin
            cnt <= cnt + 13'd1;
          end
        end

        SHIFT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!hi_half) begin
              // Rising SCLK edge: the ADC holds DOUT stable here.
              sclk    <= 1'b1;
              hi_half <= 1'b1;
              if (per >= 4'd4) shreg <= {shreg[10:0], sdat};
            end else if (per == 4'd15) begin
              state <= STOP;
              cs_n  <= 1'b1;
              saddr <= 1'b0;
              // Data just shifted in belongs to the previous frame's address.
              if (prev_ok) begin
                res_stb        <= 1'b1;
                res_ch         <= prev_addr;
                res_data       <= shreg;
                bank[prev_addr] <= shreg;
                bank_vld[prev_addr] <= 1'b1;
              end
              prev_addr <= addr;
              prev_ok   <= 1'b1;
            end else begin
              per     <= per + 4'd1;
              hi_half <= 1'b0;
              sclk    <= 1'b0;
              saddr   <= addr_bit(per + 4'd1, addr);
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end

        STOP: begin
          if (cnt == STOP_LAST) begin
            cnt <= '0;
            if (go) begin
              state     <= START;
              addr      <= nxt_addr;
              last_addr <= nxt_addr;
              cs_n      <= 1'b0;
            end else begin
              // The pending address's data will never be fetched; drop it.
              state   <= IDLE;
              busy    <= 1'b0;
              prev_ok <= 1'b0;
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data  = bank[rd_ch];
  assign rd_valid = bank_vld[rd_ch];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Purpose: directed bench for adc_scan_sequencer with a behavioural serial ADC model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        sdat = 1'b0;
  logic        sclk, cs_n, saddr, busy, res_stb, rd_valid;
  logic [2:0]  res_ch;
  logic [11:0] res_data, rd_data;
  logic [2:0]  rd_ch = 3'd0;

  adc_scan_sequencer #(.DIV(4), .GAP(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .sdat(sdat),
    .sclk(sclk), .cs_n(cs_n), .saddr(saddr), .busy(busy), .res_stb(res_stb),
    .res_ch(res_ch), .res_data(res_data), .rd_ch(rd_ch), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- ADC model and monitors (observed on falling clk) ----------------
  logic [11:0] mdl_data [8];
  logic [2:0]  model_prev = 3'd0;
  logic [2:0]  addr_cap = 3'd0;
  logic [11:0] frame_data = 12'h000;
  logic        frame_active = 1'b0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_stb = 1'b0;
  int fall_cnt = 0, rise_cnt = 0, frames = 0, stb_cnt = 0;
  int cs_fall_cyc = 0, last_rise_cyc = 0, bad_consec = 0, bad_saddr = 0;
  int sent_q[$], rises_q[$], hold_q[$], setup_q[$], csfall_q[$];
  int stb_ch_q[$], stb_dat_q[$], stb_frm_q[$], stb_cyc_q[$];

  always @(negedge clk) begin
    int per;
    if (rst) begin
      frame_active = 1'b0;
    end else begin
      if (prev_cs && !cs_n) begin
        frame_active = 1'b1;
        fall_cnt     = 0;
        rise_cnt     = 0;
        addr_cap     = 3'd0;
        frame_data   = mdl_data[model_prev];
        cs_fall_cyc  = cyc;
        csfall_q.push_back(cyc);
      end
      if (frame_active && !cs_n && prev_sclk && !sclk) begin
        if (fall_cnt == 0) setup_q.push_back(cyc - cs_fall_cyc);
        sdat = (fall_cnt >= 4 && fall_cnt <= 15) ? frame_data[15 - fall_cnt] : 1'b0;
        fall_cnt++;
      end
      if (frame_active && !cs_n && !prev_sclk && sclk) begin
        rise_cnt++;
        last_rise_cyc = cyc;
        per = fall_cnt - 1;
        if (per >= 2 && per <= 4) addr_cap = {addr_cap[1:0], saddr};
      end
      if (frame_active && !cs_n && fall_cnt > 0) begin
        per = fall_cnt - 1;
        if (saddr && !(per >= 2 && per <= 4)) bad_saddr++;
      end
      if (frame_active && !prev_cs && cs_n) begin
        frame_active = 1'b0;
        frames++;
        sent_q.push_back(int'(addr_cap));
        rises_q.push_back(rise_cnt);
        hold_q.push_back(cyc - last_rise_cyc);
        model_prev = addr_cap;
        sdat = 1'b0;
      end
      if (res_stb) begin
        stb_cnt++;
        stb_ch_q.push_back(int'(res_ch));
        stb_dat_q.push_back(int'(res_data));
        stb_frm_q.push_back(frames);
        stb_cyc_q.push_back(cyc);
        if (prev_stb) bad_consec++;
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
    prev_stb  = res_stb;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_stb(input int n, input int lim, input string tag);
    for (int i = 0; i < lim && stb_cnt < n; i++) @(negedge clk);
    chk_val(tag, stb_cnt >= n, 1);
  endtask

  task automatic wait_period(input int frame_idx, input int p, input string tag);
    int i;
    for (i = 0; i < 1000 && !(frame_active && frames == frame_idx && fall_cnt == p + 1); i++)
      @(negedge clk);
    chk_val(tag, i < 1000, 1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 400 && busy; i++) @(negedge clk);
    chk_val(tag, busy, 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int bf, bs, bc, en_cyc, cnt_cs, cnt_busy, cnt_stb;

  initial begin
    for (int i = 0; i < 8; i++) mdl_data[i] = 12'h000;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_val("rst_cs_n", cs_n, 1);
    chk_val("rst_sclk", sclk, 1);
    chk_val("rst_saddr", saddr, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_res_stb", res_stb, 0);
    chk_val("rst_res_ch", res_ch, 0);
    chk_val("rst_res_data", res_data, 0);
    chk_val("rst_rd_valid", rd_valid, 0);

    // ---- single channel 5 ----
    mdl_data[5] = 12'hA5C;
    bf = frames; bs = stb_cnt; bc = csfall_q.size();
    enable = 1'b1; ch_mask = 8'h20; en_cyc = cyc;
    wait_stb(bs + 3, 1000, "single_timeout");
    chk_val("single_start_lat", csfall_q[bc] - en_cyc, 1);
    chk_val("single_first_stb_frame", stb_frm_q[bs] - bf, 2);
    for (int k = 0; k < 3; k++) begin
      chk_val($sformatf("single_addr%0d", k), sent_q[bf + k], 5);
      chk_val($sformatf("single_ch%0d", k), stb_ch_q[bs + k], 5);
      chk_val($sformatf("single_data%0d", k), stb_dat_q[bs + k], 12'hA5C);
    end
    chk_val("single_period0", stb_cyc_q[bs + 1] - stb_cyc_q[bs], 148);
    chk_val("single_period1", stb_cyc_q[bs + 2] - stb_cyc_q[bs + 1], 148);
    chk_val("single_rises", rises_q[bf], 16);
    chk_val("single_cs_setup", setup_q[bc], 4);
    chk_val("single_cs_hold", hold_q[bf], 4);
    rd_ch = 3'd5; #1;
    chk_val("single_rd_data", rd_data, 12'hA5C);
    chk_val("single_rd_valid", rd_valid, 1);
    rd_ch = 3'd4; #1;
    chk_val("single_rd_valid_ch4", rd_valid, 0);
    @(negedge clk);
    enable = 1'b0;
    wait_idle("single_idle");

    // ---- round robin over 0,2,7 ----
    pulse_rst();
    for (int i = 0; i < 8; i++) mdl_data[i] = 12'h100 + 12'(i);
    bf = frames; bs = stb_cnt;
    enable = 1'b1; ch_mask = 8'h85;
    wait_stb(bs + 4, 1200, "rr_timeout");
    @(negedge clk);
    enable = 1'b0;
    chk_val("rr_addr0", sent_q[bf + 0], 0);
    chk_val("rr_addr1", sent_q[bf + 1], 2);
    chk_val("rr_addr2", sent_q[bf + 2], 7);
    chk_val("rr_addr3", sent_q[bf + 3], 0);
    chk_val("rr_addr4", sent_q[bf + 4], 2);
    chk_val("rr_ch0", stb_ch_q[bs + 0], 0);
    chk_val("rr_dat0", stb_dat_q[bs + 0], 12'h100);
    chk_val("rr_ch1", stb_ch_q[bs + 1], 2);
    chk_val("rr_dat1", stb_dat_q[bs + 1], 12'h102);
    chk_val("rr_ch2", stb_ch_q[bs + 2], 7);
    chk_val("rr_dat2", stb_dat_q[bs + 2], 12'h107);
    chk_val("rr_ch3", stb_ch_q[bs + 3], 0);
    chk_val("rr_dat3", stb_dat_q[bs + 3], 12'h100);
    wait_idle("rr_idle");

    // ---- reset mid-SHIFT (p=8) ----
    bf = frames;
    enable = 1'b1; ch_mask = 8'h20;
    wait_period(bf, 8, "midrst_reach_p8");
    rst = 1'b1; enable = 1'b0;
    @(negedge clk);
    chk_val("midrst_cs_n", cs_n, 1);
    chk_val("midrst_sclk", sclk, 1);
    chk_val("midrst_saddr", saddr, 0);
    chk_val("midrst_busy", busy, 0);
    chk_val("midrst_res_stb", res_stb, 0);
    chk_val("midrst_res_data", res_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c); #1;
      chk_val($sformatf("midrst_rd_valid%0d", c), rd_valid, 0);
      chk_val($sformatf("midrst_rd_data%0d", c), rd_data, 0);
    end
    @(negedge clk);

    // ---- empty mask ----
    enable = 1'b1; ch_mask = 8'h00;
    cnt_cs = 0; cnt_busy = 0; cnt_stb = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!cs_n) cnt_cs++;
      if (busy) cnt_busy++;
      if (res_stb) cnt_stb++;
    end
    chk_val("empty_cs_low_cycles", cnt_cs, 0);
    chk_val("empty_busy_cycles", cnt_busy, 0);
    chk_val("empty_stb_count", cnt_stb, 0);
    enable = 1'b0;

    // ---- enable drop at p=6 ----
    mdl_data[5] = 12'hA5C;
    bf = frames; bs = stb_cnt;
    enable = 1'b1; ch_mask = 8'h20;
    wait_stb(bs + 1, 600, "drop_first_stb");
    wait_period(bf + 2, 6, "drop_reach_p6");
    enable = 1'b0;
    wait_idle("drop_idle");
    chk_val("drop_frames", frames - bf, 3);
    chk_val("drop_rises", rises_q[bf + 2], 16);
    chk_val("drop_stb_count", stb_cnt - bs, 2);
    chk_val("drop_last_ch", stb_ch_q[bs + 1], 5);
    chk_val("drop_last_data", stb_dat_q[bs + 1], 12'hA5C);
    cnt_cs = 0;
    repeat (300) begin
      @(negedge clk);
      if (!cs_n) cnt_cs++;
    end
    chk_val("drop_stays_idle", cnt_cs, 0);
    bf = frames; bs = stb_cnt;
    enable = 1'b1;
    wait_stb(bs + 1, 600, "reen_timeout");
    chk_val("reen_dummy_frame", stb_frm_q[bs] - bf, 2);
    chk_val("reen_data", stb_dat_q[bs], 12'hA5C);
    @(negedge clk);
    enable = 1'b0;
    wait_idle("reen_idle");

    // ---- mask change at p=3 ----
    mdl_data[0] = 12'h123; mdl_data[4] = 12'h456;
    bf = frames; bs = stb_cnt;
    enable = 1'b1; ch_mask = 8'h01;
    wait_stb(bs + 1, 600, "mask_first_stb");
    wait_period(bf + 2, 3, "mask_reach_p3");
    ch_mask = 8'h10;
    wait_stb(bs + 4, 700, "mask_timeout");
    chk_val("mask_cur_addr", sent_q[bf + 2], 0);
    chk_val("mask_next_addr", sent_q[bf + 3], 4);
    chk_val("mask_stb1_ch", stb_ch_q[bs + 1], 0);
    chk_val("mask_stb2_ch", stb_ch_q[bs + 2], 0);
    chk_val("mask_stb2_data", stb_dat_q[bs + 2], 12'h123);
    chk_val("mask_stb3_ch", stb_ch_q[bs + 3], 4);
    chk_val("mask_stb3_data", stb_dat_q[bs + 3], 12'h456);
    @(negedge clk);
    enable = 1'b0;
    wait_idle("mask_idle");

    // ---- global properties ----
    chk_val("stb_never_consecutive", bad_consec, 0);
    chk_val("saddr_zero_outside_addr", bad_saddr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Autonomous channel-scan controller for the 8-channel, 12-bit serial ADC. It generates its own SPI frames (chip select, serial clock, 3-bit channel address) from the system clock and walks round-robin over a programmable channel mask. It accounts for the ADC's one-frame address pipeline and tags every 12-bit result with its channel. Results go to a per-channel result bank and a strobed result stream for downstream filtering/display logic.

## Interface
- DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- GAP, 2: SCLK periods (each 2*DIV clk cycles) with cs_n high between frames; legal range 1..15.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable.
- ch_mask  in  8  bit i set means channel i is scanned.
- sdat  in  1  ADC serial data output (DOUT).
- sclk  out  1  ADC serial clock; idles high.
- cs_n  out  1  ADC chip select, active low.
- saddr  out  1  ADC serial data input (DIN): channel address, MSB first.
- busy  out  1  high from frame start through end of STOP.
- res_stb  out  1  one-cycle pulse: res_ch/res_data valid.
- res_ch  out  3  channel of current result.
- res_data  out  12  conversion result.
- rd_ch  in  3  result bank read select.
- rd_data  out  12  last result of channel rd_ch (combinational read).
- rd_valid  out  1  channel rd_ch has been written since reset.

## Operation
- FSM: IDLE -> START -> SHIFT -> STOP -> (START, or IDLE if enable=0 or ch_mask=0).
- IDLE: cs_n=1, sclk=1, saddr=0. Leave when enable=1 and ch_mask!=0.
- START: DIV cycles; cs_n=0, sclk=1. Next address is chosen on entry: lowest set bit of ch_mask strictly above last_addr, wrapping past 7 to 0. After reset, last_addr=7, so the first address is the lowest set bit.
- SHIFT: 16 SCLK periods, numbered p=0..15. Each period is DIV cycles with sclk=0, then DIV cycles with sclk=1.
- saddr changes when sclk falls (start of period): addr[2], addr[1], addr[0] in p=2, 3, 4; 0 in all other periods.
- sdat is sampled on the clk edge that drives sclk 0->1 in p=4..15 and shifted in MSB first (D11..D0). Samples in p=0..3 are ignored.
- Address pipeline:
  - Data shifted in during frame N belongs to the address sent in frame N-1.
  - Registers prev_addr and prev_ok hold that association. prev_ok is cleared by rst and on every entry to IDLE.
  - The first frame after IDLE is a dummy: no result is emitted for it.
- STOP: GAP*2*DIV cycles; cs_n=1, sclk=1.
- On the first STOP cycle, if prev_ok=1:
  - res_stb=1, res_ch=prev_addr, res_data=shift register.
  - bank[prev_addr] is written and its valid bit set.
  - Then prev_addr<=addr and prev_ok<=1.
- res_ch/res_data hold their value until the next strobe.
- ch_mask is sampled only on START entry; changes mid-frame do not affect the current frame.
- enable falling mid-frame: the current frame completes normally, including its strobe, then the FSM goes to IDLE. The result of the last address sent is discarded.
- ch_mask becoming 0 is handled the same way at the STOP exit decision.
- rst at any point, including mid-SHIFT, gives on the next cycle: state IDLE, cs_n=1, sclk=1, saddr=0, busy=0, res_stb=0, res_ch=0, res_data=0, all bank valid bits 0, bank data 0, last_addr=7, prev_ok=0.

## Timing
- Frame period (START to next START) = DIV*(33+2*GAP) clk cycles. Default: 4*37 = 148.
- CS setup before the first SCLK fall = DIV cycles. cs_n rises DIV cycles after the last SCLK rise (p=15 high half).
- res_stb rises on the cycle cs_n goes high. It is never asserted in consecutive cycles.
- Channel-to-result latency: the result for the address sent in frame N strobes at STOP of frame N+1.
- IDLE -> START: one clk cycle after enable=1 with ch_mask!=0.
- busy=1 in START, SHIFT and STOP; 0 only in IDLE.

## Test plan
- Reset: rst held 3 cycles mid-SHIFT (p=8) -> next cycle cs_n=1, sclk=1, saddr=0, busy=0, res_stb=0, rd_valid=0 for all rd_ch.
- Single channel: ch_mask=8'h20, enable=1, ADC model returns 12'hA5C for ch5 ->
  - saddr=1,0,1 in p=2..4 of every frame.
  - No strobe in the first frame.
  - Then res_stb every 148 cycles with res_ch=5, res_data=12'hA5C; rd_ch=5 gives rd_data=12'hA5C, rd_valid=1.
- Round-robin: ch_mask=8'h85, model returns 12'h100+ch ->
  - Sent addresses 0, 2, 7, 0, 2.
  - Strobes res_ch/res_data = 0/12'h100, 2/12'h102, 7/12'h107, 0/12'h100.
- Empty mask: enable=1, ch_mask=0 for 1000 cycles -> cs_n stays 1, busy=0, no res_stb.
- Enable drop: enable->0 at p=6 of a frame ->
  - Frame completes (16 SCLK rises), its strobe occurs, then IDLE.
  - Re-enable -> the first frame is a dummy with no strobe.
- Mask change mid-frame: ch_mask 8'h01->8'h10 at p=3 ->
  - The current frame still sends address 0.
  - The next frame sends address 4; the next strobe is res_ch=0.
